// File: rtl/decode_pipe_if.sv
// decode_pipe_if: bundles the fetch-side and execute-side signals of the
// decode stage.
//   master : the fetch/execute environment. It drives flush, in_valid, in_instr,
//            in_pc and out_ready.
//   slave  : the decode stage. It drives in_ready, out_valid and the decoded
//            fields out_opcode, out_reg1, out_reg2, out_imm, out_funcode,
//            out_illegal and out_pc.
interface decode_pipe_if #(
  parameter int INSTR_W = 32,
  parameter int OPC_W   = 4,
  parameter int REG_W   = 5,
  parameter int FUNC_W  = 4,
  parameter int DATA_W  = 32
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [DATA_W-1:0]  in_pc;
  logic               out_valid;
  logic               out_ready;
  logic [OPC_W-1:0]   out_opcode;
  logic [REG_W-1:0]   out_reg1;
  logic [REG_W-1:0]   out_reg2;
  logic [DATA_W-1:0]  out_imm;
  logic [FUNC_W-1:0]  out_funcode;
  logic               out_illegal;
  logic [DATA_W-1:0]  out_pc;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_reg1, out_reg2, out_imm,
           out_funcode, out_illegal, out_pc
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_reg1, out_reg2, out_imm,
           out_funcode, out_illegal, out_pc
  );
endinterface

// File: rtl/decode_pipe.sv
// decode_pipe: pipelined instruction-decode stage. It sits between fetch and
// execute.
// Each raw instruction is split into opcode, reg1, reg2, a sign-extended
// immediate and a function code, and its illegal flag is computed. The decoded
// entry and its PC are held in a two-entry skid buffer (head plus skid).
// Ports:
//   clk : rising-edge clock.
//   rst : asynchronous, active-high reset.
//   bus : decode_pipe_if.slave. Carries the valid/ready handshakes, flush, the
//         instruction/PC inputs and the decoded outputs.
module decode_pipe #(
  parameter int INSTR_W = 32,
  parameter int OPC_W   = 4,
  parameter int REG_W   = 5,
  parameter int IMM_W   = 16,
  parameter int FUNC_W  = 4,
  parameter int DATA_W  = 32,
  parameter int NUM_OPC = 7
) (
  input  logic          clk,
  input  logic          rst,
  decode_pipe_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // Only decoded fields are stored; the raw word is never kept.
  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_W-1:0]  reg1;
    logic [REG_W-1:0]  reg2;
    logic [DATA_W-1:0] imm;
    logic [FUNC_W-1:0] funcode;
    logic              illegal;
    logic [DATA_W-1:0] pc;
  } entry_t;

  state_t state_reg, state_next;
  entry_t head_reg, head_next;
  entry_t skid_reg, skid_next;
  entry_t dec;
  logic   accept, retire;

  // Combinational field extraction. funcode overlaps the low immediate bits.
  always_comb begin
    dec.opcode  = bus.in_instr[INSTR_W-1 -: OPC_W];
    dec.reg1    = bus.in_instr[INSTR_W-OPC_W-1 -: REG_W];
    dec.reg2    = bus.in_instr[INSTR_W-OPC_W-REG_W-1 -: REG_W];
    dec.imm     = DATA_W'($signed(bus.in_instr[IMM_W-1:0]));
    dec.funcode = bus.in_instr[FUNC_W-1:0];
    dec.illegal = (32'(bus.in_instr[INSTR_W-1 -: OPC_W]) >= NUM_OPC);
    dec.pc      = bus.in_pc;
  end

  // in_ready depends on registered state only, so back-pressure from execute
  // never forms a combinational path back to fetch.
  assign bus.in_ready  = (state_reg != TWO);
  assign bus.out_valid = (state_reg != EMPTY);
  assign accept        = bus.in_valid & bus.in_ready;
  assign retire        = bus.out_valid & bus.out_ready;

  assign bus.out_opcode  = head_reg.opcode;
  assign bus.out_reg1    = head_reg.reg1;
  assign bus.out_reg2    = head_reg.reg2;
  assign bus.out_imm     = head_reg.imm;
  assign bus.out_funcode = head_reg.funcode;
  assign bus.out_illegal = head_reg.illegal;
  assign bus.out_pc      = head_reg.pc;

  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    skid_next  = skid_reg;
    if (bus.flush) begin
      // Everything buffered and any same-cycle accept are discarded.
      state_next = EMPTY;
    end else begin
      unique case (state_reg)
        EMPTY: begin
          if (accept) begin
            head_next  = dec;
            state_next = ONE;
          end
        end
        ONE: begin
          if (accept && retire) begin
            head_next = dec;
          end else if (accept) begin
            skid_next  = dec;
            state_next = TWO;
          end else if (retire) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          if (retire) begin
            head_next  = skid_reg;
            state_next = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= EMPTY;
      head_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      head_reg  <= head_next;
      skid_reg  <= skid_next;
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
module tb_decode_pipe;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  decode_pipe_if #(.INSTR_W(32), .OPC_W(4), .REG_W(5), .FUNC_W(4), .DATA_W(32)) a ();
  decode_pipe_if #(.INSTR_W(32), .OPC_W(6), .REG_W(5), .FUNC_W(4), .DATA_W(16)) b ();

  decode_pipe #(
    .INSTR_W(32), .OPC_W(4), .REG_W(5), .IMM_W(16), .FUNC_W(4), .DATA_W(32), .NUM_OPC(7)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a.slave)
  );

  decode_pipe #(
    .INSTR_W(32), .OPC_W(6), .REG_W(5), .IMM_W(12), .FUNC_W(4), .DATA_W(16), .NUM_OPC(40)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge. Sampling and driving happen 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  got_opc [8];
  logic [31:0] got_pc  [8];
  int          sent;
  int          rcv;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    a.flush = 1'b0; a.in_valid = 1'b0; a.in_instr = '0; a.in_pc = '0; a.out_ready = 1'b0;
    b.flush = 1'b0; b.in_valid = 1'b0; b.in_instr = '0; b.in_pc = '0; b.out_ready = 1'b0;
    step();
    chk("rst_valid",  64'(a.out_valid), 64'(1'b0));
    chk("rst_ready",  64'(a.in_ready),  64'(1'b1));
    chk("rst_opcode", 64'(a.out_opcode), 64'(4'd0));
    chk("rst_imm",    64'(a.out_imm),    64'(32'd0));
    chk("rst_pc",     64'(a.out_pc),     64'(32'd0));
    rst = 1'b0;
    step();

    // Single instruction
    a.in_valid = 1'b1; a.in_instr = 32'h15555524; a.in_pc = 32'h40; a.out_ready = 1'b1;
    step();
    a.in_valid = 1'b0;
    chk("single_valid",   64'(a.out_valid),   64'(1'b1));
    chk("single_opcode",  64'(a.out_opcode),  64'(4'd1));
    chk("single_reg1",    64'(a.out_reg1),    64'(5'd10));
    chk("single_reg2",    64'(a.out_reg2),    64'(5'd21));
    chk("single_imm",     64'(a.out_imm),     64'(32'h00005524));
    chk("single_funcode", 64'(a.out_funcode), 64'(4'd4));
    chk("single_illegal", 64'(a.out_illegal), 64'(1'b0));
    chk("single_pc",      64'(a.out_pc),      64'(32'h40));
    step();
    chk("single_drain", 64'(a.out_valid), 64'(1'b0));

    // Sign extension and illegal opcode
    a.in_valid = 1'b1; a.in_instr = 32'h70008000; a.in_pc = 32'h44;
    step();
    a.in_valid = 1'b0;
    chk("sext_valid",   64'(a.out_valid),   64'(1'b1));
    chk("sext_opcode",  64'(a.out_opcode),  64'(4'd7));
    chk("sext_imm",     64'(a.out_imm),     64'(32'hFFFF8000));
    chk("sext_funcode", 64'(a.out_funcode), 64'(4'd0));
    chk("sext_illegal", 64'(a.out_illegal), 64'(1'b1));
    step();
    chk("sext_drain", 64'(a.out_valid), 64'(1'b0));

    // Back-pressure: stream opcodes 0..6, instr k = {k, 24'h0, k}, pc = 0x100 + 4k
    a.in_valid = 1'b1; a.in_instr = 32'h00000000; a.in_pc = 32'h100; a.out_ready = 1'b1;
    step();
    a.out_ready = 1'b0; a.in_instr = 32'h10000001; a.in_pc = 32'h104;
    chk("bp_one_valid", 64'(a.out_valid),  64'(1'b1));
    chk("bp_one_ready", 64'(a.in_ready),   64'(1'b1));
    chk("bp_one_opc",   64'(a.out_opcode), 64'(4'd0));
    step();
    a.in_instr = 32'h20000002; a.in_pc = 32'h108;
    chk("bp_two_ready", 64'(a.in_ready),   64'(1'b0));
    chk("bp_two_opc",   64'(a.out_opcode), 64'(4'd0));
    step();
    chk("bp_hold1_ready", 64'(a.in_ready),   64'(1'b0));
    chk("bp_hold1_opc",   64'(a.out_opcode), 64'(4'd0));
    chk("bp_hold1_pc",    64'(a.out_pc),     64'(32'h100));
    step();
    chk("bp_hold2_ready", 64'(a.in_ready),   64'(1'b0));
    chk("bp_hold2_opc",   64'(a.out_opcode), 64'(4'd0));
    a.out_ready = 1'b1;
    sent = 2;
    rcv  = 0;
    for (int cyc = 0; cyc < 30 && rcv < 7; cyc++) begin
      if (a.out_valid && a.out_ready) begin
        got_opc[rcv] = a.out_opcode;
        got_pc[rcv]  = a.out_pc;
        rcv++;
      end
      if (a.in_valid && a.in_ready) sent++;
      step();
      if (sent < 7) begin
        a.in_instr = {sent[3:0], 24'h000000, sent[3:0]};
        a.in_pc    = 32'h100 + 32'(sent) * 4;
      end else begin
        a.in_valid = 1'b0;
      end
    end
    chk("bp_count", 64'(rcv), 64'(7));
    for (int k = 0; k < 7 && k < rcv; k++) begin
      chk($sformatf("bp_order_opc%0d", k), 64'(got_opc[k]), 64'(k));
      chk($sformatf("bp_order_pc%0d", k),  64'(got_pc[k]),  64'(32'h100 + 32'(k) * 4));
    end
    chk("bp_empty", 64'(a.out_valid), 64'(1'b0));

    // Flush in TWO with in_valid = 1
    a.out_ready = 1'b0; a.in_valid = 1'b1; a.in_instr = 32'h3000000A; a.in_pc = 32'h200;
    step();
    a.in_instr = 32'h4000000B; a.in_pc = 32'h204;
    step();
    chk("flush_pre_ready", 64'(a.in_ready), 64'(1'b0));
    a.flush = 1'b1; a.in_instr = 32'h5000000C; a.in_pc = 32'h208;
    step();
    a.flush = 1'b0; a.in_valid = 1'b0; a.out_ready = 1'b1;
    chk("flush_valid", 64'(a.out_valid), 64'(1'b0));
    chk("flush_ready", 64'(a.in_ready),  64'(1'b1));
    step();
    step();
    chk("flush_stays_empty", 64'(a.out_valid), 64'(1'b0));
    // Flush in ONE with a same-cycle accept: that accept is dropped too.
    a.in_valid = 1'b1; a.in_instr = 32'h2000000D; a.in_pc = 32'h20C; a.out_ready = 1'b0;
    step();
    a.flush = 1'b1; a.in_instr = 32'h6000000E; a.in_pc = 32'h210;
    step();
    a.flush = 1'b0; a.in_valid = 1'b0;
    chk("flush_one_valid", 64'(a.out_valid), 64'(1'b0));
    a.in_valid = 1'b1; a.in_instr = 32'h1000000F; a.in_pc = 32'h214; a.out_ready = 1'b1;
    step();
    a.in_valid = 1'b0;
    chk("post_flush_opc", 64'(a.out_opcode), 64'(4'd1));
    chk("post_flush_pc",  64'(a.out_pc),     64'(32'h214));
    step();

    // Asynchronous reset while in TWO, checked before the next edge
    a.out_ready = 1'b0; a.in_valid = 1'b1; a.in_instr = 32'h3000FFFF; a.in_pc = 32'h300;
    step();
    a.in_instr = 32'h40001234; a.in_pc = 32'h304;
    step();
    a.in_valid = 1'b0;
    chk("arst_pre_ready", 64'(a.in_ready), 64'(1'b0));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid",  64'(a.out_valid),  64'(1'b0));
    chk("arst_ready",  64'(a.in_ready),   64'(1'b1));
    chk("arst_opcode", 64'(a.out_opcode), 64'(4'd0));
    chk("arst_imm",    64'(a.out_imm),    64'(32'd0));
    chk("arst_pc",     64'(a.out_pc),     64'(32'd0));
    step();
    rst = 1'b0;
    a.in_valid = 1'b1; a.in_instr = 32'h20000003; a.in_pc = 32'h400; a.out_ready = 1'b1;
    step();
    a.in_valid = 1'b0;
    chk("arst_resume_opc", 64'(a.out_opcode), 64'(4'd2));
    chk("arst_resume_pc",  64'(a.out_pc),     64'(32'h400));

    // Parameter sweep instance: opcode 39 (legal) then 40 (illegal)
    b.out_ready = 1'b1; b.in_valid = 1'b1; b.in_instr = 32'h9C710800; b.in_pc = 16'h0010;
    step();
    b.in_instr = 32'hA3E007FF; b.in_pc = 16'h0014;
    chk("sweep39_opcode",  64'(b.out_opcode),  64'(6'd39));
    chk("sweep39_reg1",    64'(b.out_reg1),    64'(5'd3));
    chk("sweep39_reg2",    64'(b.out_reg2),    64'(5'd17));
    chk("sweep39_imm",     64'(b.out_imm),     64'(16'hF800));
    chk("sweep39_funcode", 64'(b.out_funcode), 64'(4'd0));
    chk("sweep39_illegal", 64'(b.out_illegal), 64'(1'b0));
    chk("sweep39_pc",      64'(b.out_pc),      64'(16'h0010));
    step();
    b.in_valid = 1'b0;
    chk("sweep40_opcode",  64'(b.out_opcode),  64'(6'd40));
    chk("sweep40_reg1",    64'(b.out_reg1),    64'(5'd31));
    chk("sweep40_reg2",    64'(b.out_reg2),    64'(5'd0));
    chk("sweep40_imm",     64'(b.out_imm),     64'(16'h07FF));
    chk("sweep40_funcode", 64'(b.out_funcode), 64'(4'hF));
    chk("sweep40_illegal", 64'(b.out_illegal), 64'(1'b1));
    chk("sweep40_pc",      64'(b.out_pc),      64'(16'h0014));
    step();
    chk("sweep_drain", 64'(b.out_valid), 64'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
